// File: rtl/bsg_counter_period_measure.sv
// bsg_counter_period_measure
//
// Receive-side counterpart of the dynamic-limit enabled counter. The far-end
// generator encodes its limit as the period of its overflow strobe; this block
// counts enabled cycles between qualified strobes (en_i & pulse_i) and presents
// each measured period on a v_o/yumi_i output port.
//
// Ports:
//   clk_i      in   1        clock, rising edge
//   reset_n_i  in   1        synchronous active-low reset
//   en_i       in   1        cycle enable shared with the generator
//   pulse_i    in   1        generator overflow strobe, ignored when en_i=0
//   v_o        out  1        measured period is valid
//   data_o     out  width_p  measured period mod 2^width_p
//   long_o     out  1        period exceeded 2^width_p, data_o is aliased
//   yumi_i     in   1        consumer takes the result (only when v_o=1)
//   overrun_o  out  1        sticky: a result was dropped while v_o was held
//   synced_o   out  1        first strobe seen, measurements are live

module bsg_counter_period_measure #(
    parameter int unsigned width_p = 16
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               en_i,
    input  logic               pulse_i,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    output logic               long_o,
    input  logic               yumi_i,
    output logic               overrun_o,
    output logic               synced_o
);

    typedef enum logic [0:0] {
        eUNSYNC = 1'b0,
        eRUN    = 1'b1
    } state_e;

    state_e             state_r, state_n;
    logic [width_p-1:0] count_r, count_n;
    logic               wrap_r,  wrap_n;
    logic               v_r,     v_n;
    logic [width_p-1:0] data_r,  data_n;
    logic               long_r,  long_n;
    logic               overrun_r, overrun_n;

    logic               qp;
    logic               res_v;
    logic [width_p-1:0] res_data;
    logic               res_long;

    assign qp = en_i & pulse_i;

    // State register and all datapath registers.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_r   <= eUNSYNC;
            count_r   <= '0;
            wrap_r    <= 1'b0;
            v_r       <= 1'b0;
            data_r    <= '0;
            long_r    <= 1'b0;
            overrun_r <= 1'b0;
        end else begin
            state_r   <= state_n;
            count_r   <= count_n;
            wrap_r    <= wrap_n;
            v_r       <= v_n;
            data_r    <= data_n;
            long_r    <= long_n;
            overrun_r <= overrun_n;
        end
    end

    // Period measurement: next state, counter and the per-strobe result.
    always_comb begin
        state_n  = state_r;
        count_n  = count_r;
        wrap_n   = wrap_r;
        res_v    = 1'b0;
        res_data = '0;
        res_long = 1'b0;

        case (state_r)
            eUNSYNC: begin
                if (qp) begin
                    state_n = eRUN;
                    count_n = '0;
                    wrap_n  = 1'b0;
                end
            end
            eRUN: begin
                if (qp) begin
                    // The strobe cycle itself is part of the period, hence +1.
                    res_v    = 1'b1;
                    res_data = count_r + 1'b1;
                    res_long = wrap_r;
                    count_n  = '0;
                    wrap_n   = 1'b0;
                end else if (en_i) begin
                    count_n = count_r + 1'b1;
                    // Only a roll-over before the strobe marks the period as
                    // longer than 2^width_p; exactly 2^width_p reads back as 0.
                    if (count_r == '1) begin
                        wrap_n = 1'b1;
                    end
                end
            end
            default: begin
                state_n = eUNSYNC;
            end
        endcase
    end

    // Output register: a held result wins over a new one, which is dropped
    // and flagged in the sticky overrun bit.
    always_comb begin
        v_n       = v_r;
        data_n    = data_r;
        long_n    = long_r;
        overrun_n = overrun_r;

        if (res_v) begin
            if (!v_r || yumi_i) begin
                v_n    = 1'b1;
                data_n = res_data;
                long_n = res_long;
            end else begin
                overrun_n = 1'b1;
            end
        end else if (yumi_i) begin
            v_n = 1'b0;
        end
    end

    assign v_o       = v_r;
    assign data_o    = data_r;
    assign long_o    = long_r;
    assign overrun_o = overrun_r;
    assign synced_o  = (state_r == eRUN);

    // Taking a result that is not there is a consumer bug.
    a_yumi_needs_v: assert property (@(posedge clk_i) disable iff (!reset_n_i) yumi_i |-> v_r);

endmodule

// File: tb/tb_bsg_counter_period_measure.sv
module tb_bsg_counter_period_measure;

    localparam int unsigned W   = 6;
    localparam longint      PER = 64;   // 2^W

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         en = 1'b0;
    logic         pulse = 1'b0;
    logic         yumi = 1'b0;
    logic         v_o;
    logic [W-1:0] data_o;
    logic         long_o;
    logic         overrun_o;
    logic         synced_o;

    bsg_counter_period_measure #(.width_p(W)) dut (
        .clk_i     (clk),
        .reset_n_i (reset_n),
        .en_i      (en),
        .pulse_i   (pulse),
        .v_o       (v_o),
        .data_o    (data_o),
        .long_o    (long_o),
        .yumi_i    (yumi),
        .overrun_o (overrun_o),
        .synced_o  (synced_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    // Behavioural model: enabled-cycle distance between strobes, plus a
    // single-slot output port.
    bit     m_synced = 0;
    longint m_p = 0;
    bit     m_v = 0;
    longint m_data = 0;
    bit     m_long = 0;
    bit     m_ovr = 0;

    int gcnt = 0;   // generator's enabled-cycle count since its last strobe

    task automatic cmp(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit     res;
        longint rd;
        bit     rl;
        res = 0; rd = 0; rl = 0;
        if (!reset_n) begin
            m_synced = 0; m_p = 0; m_v = 0; m_data = 0; m_long = 0; m_ovr = 0;
        end else begin
            if (en) begin
                if (!m_synced) begin
                    if (pulse) begin
                        m_synced = 1;
                        m_p = 0;
                    end
                end else begin
                    m_p++;
                    if (pulse) begin
                        res = 1;
                        rd  = m_p % PER;
                        rl  = (m_p > PER);
                        m_p = 0;
                    end
                end
            end
            if (res) begin
                if (!m_v || yumi) begin
                    m_v = 1; m_data = rd; m_long = rl;
                end else begin
                    m_ovr = 1;
                end
            end else if (yumi) begin
                m_v = 0;
            end
        end
    endtask

    // Called at posedge+1: drive inputs, let one edge pass, update the model.
    task automatic step(input bit rn, input bit e, input bit p, input bit y_want);
        reset_n = rn;
        en      = e;
        pulse   = p;
        yumi    = y_want && v_o && m_v;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
        gcnt = 0;
    endtask

    // Generator with limit lim (0 means 2^W), en duty en_pct, yumi
    // probability y_pct, and optional stray pulses while disabled.
    task automatic gen(input int lim, input int n, input int en_pct, input int y_pct, input bit stray);
        int lp;
        bit e, p, y;
        lp = (lim == 0) ? int'(PER) : lim;
        for (int i = 0; i < n; i++) begin
            e = ($urandom_range(99) < en_pct);
            y = ($urandom_range(99) < y_pct);
            if (e) begin
                p = (gcnt + 1 == lp);
                gcnt = p ? 0 : gcnt + 1;
            end else begin
                p = stray && ($urandom_range(1) == 1);
            end
            step(1'b1, e, p, y);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp("v_o",       v_o,       m_v);
            cmp("data_o",    data_o,    m_data);
            cmp("long_o",    long_o,    m_long);
            cmp("overrun_o", overrun_o, m_ovr);
            cmp("synced_o",  synced_o,  m_synced);
        end
    end

    initial begin
        #1;
        do_reset(2);
        chk_en = 1'b1;
        cmp("rst_v", v_o, 0);
        cmp("rst_synced", synced_o, 0);
        cmp("rst_overrun", overrun_o, 0);

        // Steady limit 5, consumer always ready.
        gen(5, 5, 100, 100, 0);
        cmp("t1_synced", synced_o, 1);
        cmp("t1_no_result", v_o, 0);
        gen(5, 5, 100, 100, 0);
        cmp("t1_v", v_o, 1);
        cmp("t1_data", data_o, 5);
        cmp("t1_long", long_o, 0);
        gen(5, 40, 100, 100, 0);

        // Half-duty enable with stray pulses while disabled.
        do_reset(1);
        gen(3, 80, 50, 100, 1);
        cmp("t2_data", data_o, 3);

        // Exactly 2^W, then 2^W+1 enabled cycles.
        do_reset(1);
        gen(0, 64, 100, 100, 0);
        gen(0, 64, 100, 100, 0);
        cmp("t3_exact_data", data_o, 0);
        cmp("t3_exact_long", long_o, 0);
        gen(65, 65, 100, 100, 0);
        cmp("t3_long_data", data_o, 1);
        cmp("t3_long_long", long_o, 1);

        // Consumer stalls across two periods of 4.
        do_reset(1);
        gen(4, 8, 100, 0, 0);
        gen(4, 4, 100, 0, 0);
        cmp("t4_data", data_o, 4);
        cmp("t4_overrun", overrun_o, 1);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        cmp("t4_v_clear", v_o, 0);
        cmp("t4_overrun_sticky", overrun_o, 1);

        // Strobe coincident with yumi while v_o=1.
        do_reset(1);
        gen(4, 8, 100, 0, 0);
        gen(6, 5, 100, 0, 0);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        gcnt = 0;
        cmp("t5_data", data_o, 6);
        cmp("t5_v", v_o, 1);
        cmp("t5_overrun", overrun_o, 0);

        // One-cycle reset mid-period while a result is held.
        do_reset(1);
        gen(3, 6, 100, 0, 0);
        gen(3, 1, 100, 0, 0);
        do_reset(1);
        cmp("t6_v", v_o, 0);
        cmp("t6_synced", synced_o, 0);
        cmp("t6_overrun", overrun_o, 0);
        gen(3, 3, 100, 0, 0);
        cmp("t6_resync", synced_o, 1);
        cmp("t6_no_result", v_o, 0);

        // Randomised segments with occasional resets.
        for (int s = 0; s < 60; s++) begin
            if ($urandom_range(9) == 0) do_reset(1);
            gen($urandom_range(70), $urandom_range(150, 10), $urandom_range(100, 30),
                $urandom_range(100), $urandom_range(1) == 1);
        end

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
